// File: rtl/ray_hit_point.sv
// Reconstructs the world-space ray/wall hit point ori + p*dir and its maze cell.
// Both axes share one 18-step serial shift-add multiply, with valid/ready on each side.
module ray_hit_point #(
    parameter int FRAC       = 8,
    parameter int CELL_SHIFT = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [18:0]        p,
    input  logic signed [9:0]  dir_x,
    input  logic signed [9:0]  dir_y,
    input  logic signed [9:0]  ori_x,
    input  logic signed [9:0]  ori_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [21:0] hit_x,
    output logic signed [21:0] hit_y,
    output logic signed [15:0] cell_x,
    output logic signed [15:0] cell_y,
    output logic               no_hit
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [17:0]         r_m;
    logic [27:0]         r_add_x;
    logic [27:0]         r_add_y;
    logic [27:0]         r_acc_x;
    logic [27:0]         r_acc_y;
    logic                r_neg_x;
    logic                r_neg_y;
    logic signed [9:0]   r_ori_x;
    logic signed [9:0]   r_ori_y;
    logic                r_nohit;
    logic [4:0]          r_cnt;
    logic signed [21:0]  r_hit_x;
    logic signed [21:0]  r_hit_y;
    logic signed [15:0]  r_cell_x;
    logic signed [15:0]  r_cell_y;
    logic                r_no_hit;
    logic                w_accept;
    logic signed [21:0]  w_hit_x;
    logic signed [21:0]  w_hit_y;

    // -512 maps to 512, which still fits the 10-bit unsigned magnitude.
    function automatic logic [9:0] abs10(input logic signed [9:0] d);
        logic [9:0] u;
        u = d;
        return u[9] ? (~u + 10'd1) : u;
    endfunction

    function automatic logic [19:0] trunc_mag(input logic [27:0] acc);
        return 20'(acc >> FRAC);
    endfunction

    function automatic logic signed [21:0] apply_sign(input logic signed [9:0] ori,
                                                      input logic neg,
                                                      input logic [19:0] mag);
        logic signed [21:0] o;
        logic signed [21:0] m;
        o = {{12{ori[9]}}, ori};
        m = {2'b00, mag};
        return neg ? (o - m) : (o + m);
    endfunction

    function automatic logic signed [15:0] cell_of(input logic signed [21:0] h);
        return 16'(h >>> CELL_SHIFT);
    endfunction

    assign in_ready  = (r_state == S_IDLE) && rst_n;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign w_hit_x   = apply_sign(r_ori_x, r_neg_x, trunc_mag(r_acc_x));
    assign w_hit_y   = apply_sign(r_ori_y, r_neg_y, trunc_mag(r_acc_y));
    assign hit_x     = r_hit_x;
    assign hit_y     = r_hit_y;
    assign cell_x    = r_cell_x;
    assign cell_y    = r_cell_y;
    assign no_hit    = r_no_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_MUL;
            S_MUL:   if (r_cnt == 5'd17) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m      <= '0;
            r_add_x  <= '0;
            r_add_y  <= '0;
            r_acc_x  <= '0;
            r_acc_y  <= '0;
            r_neg_x  <= 1'b0;
            r_neg_y  <= 1'b0;
            r_ori_x  <= '0;
            r_ori_y  <= '0;
            r_nohit  <= 1'b0;
            r_cnt    <= '0;
            r_hit_x  <= '0;
            r_hit_y  <= '0;
            r_cell_x <= '0;
            r_cell_y <= '0;
            r_no_hit <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_m     <= p[17:0];
                        r_add_x <= {18'd0, abs10(dir_x)};
                        r_add_y <= {18'd0, abs10(dir_y)};
                        r_neg_x <= dir_x[9];
                        r_neg_y <= dir_y[9];
                        r_ori_x <= ori_x;
                        r_ori_y <= ori_y;
                        r_nohit <= p[18];
                        r_acc_x <= '0;
                        r_acc_y <= '0;
                        r_cnt   <= '0;
                    end
                end
                // Multiplier bit i is always at r_m[0], its partial product at r_add.
                S_MUL: begin
                    if (r_m[0] && !r_nohit) begin
                        r_acc_x <= r_acc_x + r_add_x;
                        r_acc_y <= r_acc_y + r_add_y;
                    end
                    r_m     <= r_m >> 1;
                    r_add_x <= r_add_x << 1;
                    r_add_y <= r_add_y << 1;
                    r_cnt   <= r_cnt + 5'd1;
                end
                S_FIN: begin
                    r_hit_x  <= w_hit_x;
                    r_hit_y  <= w_hit_y;
                    r_cell_x <= cell_of(w_hit_x);
                    r_cell_y <= cell_of(w_hit_y);
                    r_no_hit <= r_nohit;
                end
                default: ;
            endcase
        end
    end

endmodule
